// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: fetch FSM encoding, main-control opcodes
// and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_DROP = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/pc_reg.sv
// Program counter: sequential +4 advance or word-aligned branch redirect.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic        incr_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_o       = pc_q;

  // Redirect wins over the sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = word_align(target_i);
    end else if (incr_i) begin
      pc_d = pc_plus4_o;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM plus the registered
// instruction/pc_plus4 handoff to decode.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  if_stage_if.master        imem,
  output logic [31:0]       instr,
  output logic [5:0]        op_code,
  output logic [31:0]       pc_plus4,
  output logic              instr_valid,
  output logic              fetch_err
);

  localparam logic [1:0] ST_IDLE = FS_IDLE;
  localparam logic [1:0] ST_REQ  = FS_REQ;
  localparam logic [1:0] ST_WAIT = FS_WAIT;
  localparam logic [1:0] ST_DROP = FS_DROP;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic        req_s;
  logic        capture_s;
  logic [31:0] pc_s;
  logic [31:0] pc_inc_s;

  assign req_s     = (state_q == ST_REQ) && !branch_taken && !(instr_valid_q && stall);
  assign capture_s = (state_q == ST_WAIT) && imem.rvalid && !branch_taken;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .redirect_i (branch_taken),
    .incr_i     (capture_s),
    .target_i   (branch_target),
    .pc_o       (pc_s),
    .pc_plus4_o (pc_inc_s)
  );

  assign imem.req    = req_s;
  assign imem.addr   = pc_s;
  assign instr       = instr_q;
  assign op_code     = instr_q[31:26];
  assign pc_plus4    = pc_plus4_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

  // Fetch FSM; a branch with the response still in flight parks in DROP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (req_s && imem.gnt) state_d = ST_WAIT;
        else                   state_d = ST_REQ;
      end
      ST_WAIT: begin
        if (branch_taken)     state_d = imem.rvalid ? ST_REQ : ST_DROP;
        else if (imem.rvalid) state_d = ST_REQ;
        else                  state_d = ST_WAIT;
      end
      ST_DROP: begin
        if (imem.rvalid) state_d = ST_REQ;
        else             state_d = ST_DROP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode handoff: branch flushes, stall holds a valid word, otherwise drain.
  always_comb begin
    instr_d       = instr_q;
    pc_plus4_d    = pc_plus4_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = branch_taken && (branch_target[1:0] != 2'b00);
    if (branch_taken) begin
      instr_valid_d = 1'b0;
    end else if (capture_s) begin
      instr_d       = imem.rdata;
      pc_plus4_d    = pc_inc_s;
      instr_valid_d = 1'b1;
    end else if (!stall) begin
      instr_valid_d = 1'b0;
    end else begin
      instr_valid_d = instr_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instr_q       <= 32'h0000_0000;
      pc_plus4_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset (word-aligned).
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 stall  input  1  decode not accepting; held instruction SHALL stay unchanged.
REQ-005 branch_taken  input  1  redirect request from the branch resolution stage.
REQ-006 branch_target  input  32  redirect address.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  fetch address, equal to the current PC.
REQ-009 imem_gnt  input  1  memory accepts the request this cycle.
REQ-010 imem_rvalid  input  1  read data valid; at least 1 cycle after grant.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 instr  output  32  registered instruction to decode.
REQ-013 op_code  output  6  instr[31:26], feeding main control.
REQ-014 pc_plus4  output  32  address of instr plus 4.
REQ-015 instr_valid  output  1  instr/op_code/pc_plus4 are valid.
REQ-016 fetch_err  output  1  one-cycle pulse on a misaligned branch_target.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and DROP, with at most one outstanding memory request.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-019 imem_req SHALL be (state==REQ) && !branch_taken && !(instr_valid && stall).
REQ-020 REQ with imem_req && imem_gnt: go to WAIT. Without grant, hold address and request.
REQ-021 WAIT with imem_rvalid: instr<=imem_rdata, pc_plus4<=PC+4, PC<=PC+4, instr_valid<=1, go to REQ.
REQ-022 Latency: grant in cycle t and rvalid in t+1 SHALL give instr_valid high in cycle t+2.
REQ-023 instr_valid SHALL clear when stall=0 and no new data is captured that cycle.
REQ-024 While stall=1 and instr_valid=1, instr, op_code and pc_plus4 SHALL hold.
REQ-025 branch_taken in any state SHALL load PC<=branch_target with bits[1:0] forced to 0 and clear instr_valid next cycle, overriding stall.
REQ-026 If branch_target[1:0]!=0, fetch_err SHALL pulse for exactly one cycle.
REQ-027 Branch in WAIT without rvalid: go to DROP. Branch in WAIT with rvalid the same cycle: discard the data and go to REQ.
REQ-028 DROP SHALL discard the next rvalid data without updating outputs, then go to REQ. A branch in DROP updates PC and stays in DROP.
REQ-029 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-030 imem_rvalid outside WAIT/DROP SHALL be ignored.

Reset
REQ-031 Asserting rst SHALL immediately set state=IDLE, PC=RESET_PC, instr=0, pc_plus4=0, instr_valid=0, fetch_err=0 and imem_req=0, including mid-request. Any late rvalid after release SHALL be ignored by the IDLE/REQ states.

Structure
REQ-032 Package mips_pkg SHALL hold the fetch state enum, the opcode constants (R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100) and the reset-PC default.
REQ-033 Sub-module pc_reg SHALL hold the PC register with +4 and redirect muxing. The FSM and output register SHALL stay in if_stage.

Verification
REQ-034 Reset release, gnt same cycle, rvalid next cycle, no stall -> addresses 0,4,8 issued; instr_valid in cycles t+2; pc_plus4=4,8,12.
REQ-035 Return data 32'h8C000000 then hold stall=1 for 3 cycles -> op_code=6'b100011 held; imem_req=0 while stalled and valid.
REQ-036 branch_taken with target 32'h40 in WAIT before rvalid -> DROP; returned word discarded; next imem_addr=32'h40.
REQ-037 branch_target=32'h43 -> fetch_err one-cycle pulse; next fetch address 32'h40.
REQ-038 rst asserted during WAIT, with rvalid arriving after release -> outputs zero, first request at RESET_PC, stale data not captured.
REQ-039 PC=32'hFFFF_FFFC fetched -> pc_plus4=0 and next imem_addr=0.
